// File: rtl/input_debounce_sync.sv
// input_debounce_sync: two independent synchronize-and-debounce lanes
// (lane 0 = din, lane 1 = en) feeding registered, hazard-free levels.
// Optional build macro EDGE_DETECT_EN: when defined, registered one-cycle
// din_rise / din_fall pulses are produced; otherwise they are tied low.

module input_debounce_lane #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          EDGE_EN         = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, CHECK} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   take;

    assign sync = sync_q[SYNC_STAGES-1];

    // Level flips on this edge: immediate accept when one sample suffices,
    // otherwise when the last qualifying sample of CHECK still disagrees.
    assign take = (sync != level) &&
                  (((state == STABLE) && (DEBOUNCE_CYCLES == 1)) ||
                   ((state == CHECK)  && (cnt == CNT_MAX)));

    // Metastability chain; the raw input only ever touches sync_q[0].
    always_ff @(posedge clk) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    // Debounce FSM: any sample matching level drops back to STABLE and
    // discards the partial count, so qualification restarts from zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (sync == level) begin
                        cnt <= '0;
                    end else if (DEBOUNCE_CYCLES == 1) begin
                        level <= sync;
                    end else begin
                        state <= CHECK;
                        cnt   <= CW'(1);
                    end
                end
                CHECK: begin
                    if (sync == level) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (take) begin
                        level <= sync;
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    generate
        if (EDGE_EN) begin : g_edge
            // Pulses register on the same edge that moves level.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    rise <= 1'b0;
                    fall <= 1'b0;
                end else begin
                    rise <= take &  sync;
                    fall <= take & ~sync;
                end
            end
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate
endmodule

module input_debounce_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DIN_INVERT      = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic din_raw,
    input  logic en_raw,
    output logic din_rvs,
    output logic en,
    output logic din_rise,
    output logic din_fall
);
    localparam int unsigned NUM_LANES = 2;

`ifdef EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic [NUM_LANES-1:0] lane_raw;
    logic [NUM_LANES-1:0] lane_level;
    logic [NUM_LANES-1:0] lane_rise;
    logic [NUM_LANES-1:0] lane_fall;

    assign lane_raw = {en_raw, din_raw};

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            // Only the din lane carries edge flops; the en lane ties them low.
            input_debounce_lane #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .EDGE_EN         ((i == 0) ? EDGE_EN : 1'b0)
            ) u_lane (
                .clk   (clk),
                .rstn  (rstn),
                .raw   (lane_raw[i]),
                .level (lane_level[i]),
                .rise  (lane_rise[i]),
                .fall  (lane_fall[i])
            );
        end
    endgenerate

    // XOR with a constant keeps din_rvs a direct flop output.
    assign din_rvs  = lane_level[0] ^ DIN_INVERT[0];
    assign en       = lane_level[1];
    // Non-din lanes drive constant 0, so the OR only passes lane 0.
    assign din_rise = |lane_rise;
    assign din_fall = |lane_fall;
endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed bench for input_debounce_sync: default DUT (2 sync, 16 debounce,
// inverted din) plus a DEBOUNCE_CYCLES=1 instance for the short-latency case.
// Pulse expectations follow EDGE_DETECT_EN as seen by this compilation.

module tb_input_debounce_sync;
    logic clk = 1'b0;
    logic rstn;
    logic din_raw, en_raw, din_rvs, en, din_rise, din_fall;
    logic din_raw1, en_raw1, din_rvs1, en1, din_rise1, din_fall1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    input_debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .DIN_INVERT(1)) u_dut (
        .clk(clk), .rstn(rstn), .din_raw(din_raw), .en_raw(en_raw),
        .din_rvs(din_rvs), .en(en), .din_rise(din_rise), .din_fall(din_fall)
    );

    input_debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .DIN_INVERT(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .din_raw(din_raw1), .en_raw(en_raw1),
        .din_rvs(din_rvs1), .en(en1), .din_rise(din_rise1), .din_fall(din_fall1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; din_raw = 1'b1; en_raw = 1'b1; din_raw1 = 1'b0; en_raw1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({din_rvs, en, din_rise, din_fall} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=1000", k, {din_rvs, en, din_rise, din_fall});
            end
            checks++;
            if ({din_rvs1, en1, din_rise1, din_fall1} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_outputs_d1 cyc=%0d got=%b exp=1000", k, {din_rvs1, en1, din_rise1, din_fall1});
            end
        end
        rstn = 1'b1; din_raw = 1'b0; en_raw = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if ({din_rvs, en} !== 2'b10) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=10", {din_rvs, en});
        end
    endtask

    // Step din to val and watch 20 edges; level moves at edge 18.
    task automatic test_step(input logic val);
        logic exp_rvs, exp_rise, exp_fall;
        din_raw = val;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_rvs = (k >= 18) ? ~val : val;
`ifdef EDGE_DETECT_EN
            exp_rise = (k == 18) &&  val;
            exp_fall = (k == 18) && !val;
`else
            exp_rise = 1'b0;
            exp_fall = 1'b0;
`endif
            checks++;
            if (din_rvs !== exp_rvs) begin
                failures++;
                $display("FAIL step_din_rvs val=%b edge=%0d got=%b exp=%b", val, k, din_rvs, exp_rvs);
            end
            checks++;
            if ({din_rise, din_fall} !== {exp_rise, exp_fall}) begin
                failures++;
                $display("FAIL step_pulse val=%b edge=%0d got=%b exp=%b", val, k, {din_rise, din_fall}, {exp_rise, exp_fall});
            end
            checks++;
            if (en !== 1'b0) begin
                failures++;
                $display("FAIL step_en_quiet edge=%0d got=%b exp=0", k, en);
            end
        end
    endtask

    // High 10, low 1, then high: last rise before edge 12, level at edge 29.
    task automatic test_bounce();
        logic exp_rvs, exp_rise;
        for (int k = 1; k <= 32; k++) begin
            din_raw = (k == 11) ? 1'b0 : 1'b1;
            tick();
            exp_rvs = (k >= 29) ? 1'b0 : 1'b1;
`ifdef EDGE_DETECT_EN
            exp_rise = (k == 29);
`else
            exp_rise = 1'b0;
`endif
            checks++;
            if (din_rvs !== exp_rvs) begin
                failures++;
                $display("FAIL bounce_din_rvs edge=%0d got=%b exp=%b", k, din_rvs, exp_rvs);
            end
            checks++;
            if (din_rise !== exp_rise) begin
                failures++;
                $display("FAIL bounce_rise edge=%0d got=%b exp=%b", k, din_rise, exp_rise);
            end
        end
        din_raw = 1'b0;
        for (int k = 1; k <= 20; k++) tick();
        checks++;
        if (din_rvs !== 1'b1) begin
            failures++;
            $display("FAIL bounce_restore got=%b exp=1", din_rvs);
        end
    endtask

    task automatic test_simultaneous();
        din_raw = 1'b1; en_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({din_rvs, en} !== ((k >= 18) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL simul_levels edge=%0d got=%b exp=%b", k, {din_rvs, en}, (k >= 18) ? 2'b01 : 2'b10);
            end
        end
        din_raw = 1'b0; en_raw = 1'b0;
        for (int k = 1; k <= 20; k++) tick();
        checks++;
        if ({din_rvs, en} !== 2'b10) begin
            failures++;
            $display("FAIL simul_restore got=%b exp=10", {din_rvs, en});
        end
    endtask

    // cnt reaches 8 after edge 10; reset there and restart the count.
    task automatic test_reset_mid_check();
        din_raw = 1'b1; en_raw = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        rstn = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if ({din_rvs, en, din_rise, din_fall} !== 4'b1000) begin
                failures++;
                $display("FAIL midchk_reset cyc=%0d got=%b exp=1000", k, {din_rvs, en, din_rise, din_fall});
            end
        end
        rstn = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            checks++;
            if ({din_rvs, en} !== ((k >= 18) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL midchk_release edge=%0d got=%b exp=%b", k, {din_rvs, en}, (k >= 18) ? 2'b01 : 2'b10);
            end
        end
    endtask

    // DEBOUNCE_CYCLES=1 instance: level moves at edge 3.
    task automatic test_short_debounce();
        logic exp_rise;
        din_raw1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
`ifdef EDGE_DETECT_EN
            exp_rise = (k == 3);
`else
            exp_rise = 1'b0;
`endif
            checks++;
            if (din_rvs1 !== ((k >= 3) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL d1_din_rvs edge=%0d got=%b exp=%b", k, din_rvs1, (k >= 3) ? 1'b0 : 1'b1);
            end
            checks++;
            if ({din_rise1, en1} !== {exp_rise, 1'b0}) begin
                failures++;
                $display("FAIL d1_rise_en edge=%0d got=%b exp=%b", k, {din_rise1, en1}, {exp_rise, 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_step(1'b1);
        test_step(1'b0);
        test_bounce();
        test_simultaneous();
        test_reset_mid_check();
        test_short_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/input_debounce_sync.md
# input_debounce_sync

Input conditioning stage directly upstream of the registered flag stage. It takes two asynchronous, possibly bouncing raw inputs, synchronizes each into the clk domain and debounces it. It then drives the clean, glitch-free, registered `din_rvs` and `en` levels that the downstream stage ANDs and registers. Every output comes straight from a flop, so the downstream combinational term never sees a hazard caused by skewed asynchronous edges.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop depth per channel; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, 16: number of consecutive synchronized samples that must differ from the current level before that level changes; legal range ≥ 1.
- `DIN_INVERT`, 1: 1 → `din_rvs` is the inverted debounced `din_raw`; 0 → `din_rvs` is non-inverted.
- `clk` in 1: system clock; all flops are clocked on its rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `din_raw` in 1: asynchronous raw data input.
- `en_raw` in 1: asynchronous raw enable input.
- `din_rvs` out 1: debounced `din_raw` level, XOR `DIN_INVERT`; registered.
- `en` out 1: debounced `en_raw` level; registered.
- `din_rise` out 1: one-cycle pulse on a debounced 0→1 change of `din_raw` (taken before inversion).
- `din_fall` out 1: one-cycle pulse on a debounced 1→0 change of `din_raw` (taken before inversion).

## Operation
- There are two identical, independent channels: din and en. Each channel is built as:
  - a `SYNC_STAGES`-deep flop chain;
  - a debounce FSM;
  - a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`;
  - a `level` register.
- FSM state STABLE:
  - if `sync == level`: stay, `cnt = 0`;
  - else if `DEBOUNCE_CYCLES == 1`: `level <= sync`, stay in STABLE;
  - else: go to CHECK, `cnt <= 1`.
- FSM state CHECK:
  - if `sync == level`: the change was a bounce; go to STABLE, `cnt <= 0`, `level` unchanged;
  - else if `cnt == DEBOUNCE_CYCLES-1`: `level <= sync`, go to STABLE, `cnt <= 0`;
  - else: `cnt <= cnt + 1`.
- The counter never wraps. Its maximum value is `DEBOUNCE_CYCLES-1`.
- Outputs:
  - `din_rvs = din level ^ DIN_INVERT`;
  - `en = en level`.
- Edge pulses:
  - `din_rise` is registered high in the same edge that sets the din `level` from 0 to 1;
  - `din_fall` is registered high in the same edge that clears it from 1 to 0;
  - each pulse lasts exactly one cycle.
- The channels never interact. A simultaneous change on both raw inputs is debounced independently, and both outputs update on the same edge.

## Timing
- Reset values, applied at the first rising clk edge with `rstn = 0`:
  - all sync flops = 0;
  - `level` = 0, `cnt` = 0, state = STABLE;
  - `din_rvs = DIN_INVERT`, `en = 0`, `din_rise = 0`, `din_fall = 0`.
- Reset taken mid-CHECK abandons the pending change. After release, a stable input at 1 needs the full latency before it propagates.
- Latency: a raw change that meets setup before edge 1 and then holds is visible on the outputs after edge `SYNC_STAGES + DEBOUNCE_CYCLES`. With the defaults this is edge 18.
- Pulse rejection:
  - a raw pulse shorter than `DEBOUNCE_CYCLES` synchronized samples never changes `level`;
  - one sample returning to `level` restarts the qualification from zero.
- Minimum spacing between two accepted transitions on one channel is `DEBOUNCE_CYCLES` cycles.
- There is no handshake. Outputs are free-running levels and pulses.

## Configuration
- `EDGE_DETECT_EN` defined:
  - `din_rise` and `din_fall` are generated as described above.
- `EDGE_DETECT_EN` undefined:
  - the edge logic is removed;
  - `din_rise` and `din_fall` are tied to constant 0;
  - `din_rvs`, `en` and the debounce behaviour are unchanged.
- Port list is identical in both builds.

## Test plan
1. Reset, defaults:
   - stimulus: hold `rstn = 0` for 3 cycles with `din_raw = 1`, `en_raw = 1`;
   - required: `din_rvs = 1`, `en = 0`, `din_rise = 0`, `din_fall = 0` throughout reset.
2. Clean step:
   - stimulus: after reset release, `din_raw` goes 0→1 before edge 1 and holds;
   - required: `din_rvs` falls 1→0 after edge 18;
   - required (`EDGE_DETECT_EN` defined): `din_rise` is high for exactly that one cycle.
3. Bounce rejection:
   - stimulus: `din_raw` toggles high for 10 cycles, low for 1 cycle, then high and holds;
   - required: no output change during the toggling; `din_rvs` changes 16 synchronized samples after the final rise.
4. Simultaneous inputs:
   - stimulus: `din_raw` and `en_raw` both rise on the same edge;
   - required: `en` and `din_rvs` update on the same edge (edge 18).
5. Reset mid-CHECK:
   - stimulus: assert `rstn = 0` at `cnt = 8`, then release with the input still high;
   - required: outputs return to their reset values and need a full 18 cycles before updating.
6. Configuration build:
   - stimulus: build with `EDGE_DETECT_EN` undefined and `DEBOUNCE_CYCLES = 1`, then repeat scenario 2;
   - required: `din_rvs` changes after edge 3; `din_rise` stays 0.
